// File: rtl/fft_stream_pkg.sv
// Constants and helpers shared by the FFT output streaming blocks.
package fft_stream_pkg;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_FRAME_LEN = 256;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction
endpackage

// File: rtl/acc_ram.sv
// Accumulation buffer: synchronous write, raw read port for read-modify-write,
// bypassed read port for the drain side.
module acc_ram
  import fft_stream_pkg::*;
#(
  parameter int  DEPTH = DEF_FRAME_LEN,
  parameter int  W     = DEF_DATA_W,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [AW-1:0]       waddr_i,
  input  logic signed [W-1:0] wdata_i,
  input  logic [AW-1:0]       raddr_a_i,
  output logic signed [W-1:0] rdata_a_o,
  input  logic [AW-1:0]       raddr_b_i,
  output logic signed [W-1:0] rdata_b_o
);
  logic signed [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Port A feeds the adder that produces wdata, so it must not see the bypass.
  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = (we_i && (waddr_i == raddr_b_i)) ? wdata_i : mem_q[raddr_b_i];
endmodule

// File: rtl/frame_accumulator.sv
// Sums NUM_FRAMES FFT frames bin by bin, then streams the saturated sum or the
// average with a tlast marker.
module frame_accumulator
  import fft_stream_pkg::*;
#(
  parameter int  DATA_W     = DEF_DATA_W,
  parameter int  FRAME_LEN  = DEF_FRAME_LEN,
  parameter int  NUM_FRAMES = 2,
  parameter int  AVG_MODE   = 1,
  localparam int LOG_NF     = clog2(NUM_FRAMES),
  localparam int ACC_W      = DATA_W + LOG_NF,
  localparam int AW         = clog2(FRAME_LEN),
  localparam int FW         = (LOG_NF > 0) ? LOG_NF : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  input  logic signed [DATA_W-1:0] i_data,
  input  logic                     i_data_valid,
  output logic                     o_data_ready,
  output logic signed [DATA_W-1:0] o_data,
  output logic                     o_data_valid,
  output logic                     o_data_last,
  input  logic                     i_data_ready,
  output logic                     o_overflow
);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  state_e                   state_q;
  logic [AW-1:0]            samp_q, rd_q;
  logic [FW-1:0]            frm_q;
  logic signed [DATA_W-1:0] data_q;
  logic                     vld_q, last_q, ovf_q, rdy_q;

  logic                     accept, take, last_in, sat_d;
  logic signed [ACC_W-1:0]  din_ext, rd_a, rd_b, wdata;
  logic [AW-1:0]            raddr_b;
  logic signed [DATA_W-1:0] conv_d;

  assign accept  = i_data_valid && rdy_q && !i_flush;
  assign take    = vld_q && i_data_ready && !i_flush;
  assign last_in = (samp_q == AW'(FRAME_LEN-1)) && (frm_q == FW'(NUM_FRAMES-1));
  assign din_ext = ACC_W'(i_data);
  assign wdata   = (frm_q == '0) ? din_ext : rd_a + din_ext;
  // Drain port looks one bin ahead so the output register reloads on the take edge.
  assign raddr_b = (state_q == ST_DRAIN) ? rd_q + AW'(1) : '0;

  acc_ram #(.DEPTH(FRAME_LEN), .W(ACC_W)) u_ram (
    .clk_i     (i_clk),
    .we_i      (accept),
    .waddr_i   (samp_q),
    .wdata_i   (wdata),
    .raddr_a_i (samp_q),
    .rdata_a_o (rd_a),
    .raddr_b_i (raddr_b),
    .rdata_b_o (rd_b)
  );

  always_comb begin
    conv_d = DATA_W'(rd_b >>> LOG_NF);
    sat_d  = 1'b0;
    if (AVG_MODE == 0) begin
      conv_d = rd_b[DATA_W-1:0];
      if (rd_b > SAT_MAX) begin
        conv_d = {1'b0, {(DATA_W-1){1'b1}}};
        sat_d  = 1'b1;
      end else if (rd_b < SAT_MIN) begin
        conv_d = {1'b1, {(DATA_W-1){1'b0}}};
        sat_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_ACCUM;
      samp_q  <= '0;
      frm_q   <= '0;
      rd_q    <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else if (i_flush) begin
      state_q <= ST_ACCUM;
      samp_q  <= '0;
      frm_q   <= '0;
      rd_q    <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
      rdy_q   <= 1'b1;
    end else if (state_q == ST_ACCUM) begin
      rdy_q <= 1'b1;
      if (accept) begin
        samp_q <= samp_q + AW'(1);
        if (samp_q == AW'(FRAME_LEN-1)) frm_q <= last_in ? '0 : frm_q + FW'(1);
        if (last_in) begin
          state_q <= ST_DRAIN;
          rdy_q   <= 1'b0;
          vld_q   <= 1'b1;
          rd_q    <= '0;
          data_q  <= conv_d;
          last_q  <= 1'b0;
          ovf_q   <= ovf_q | sat_d;
        end
      end
    end else if (take) begin
      if (last_q) begin
        state_q <= ST_ACCUM;
        vld_q   <= 1'b0;
        last_q  <= 1'b0;
        rd_q    <= '0;
        rdy_q   <= 1'b1;
      end else begin
        rd_q   <= rd_q + AW'(1);
        data_q <= conv_d;
        last_q <= (rd_q == AW'(FRAME_LEN-2));
        ovf_q  <= ovf_q | sat_d;
      end
    end
  end

  assign o_data_ready = rdy_q;
  assign o_data       = data_q;
  assign o_data_valid = vld_q;
  assign o_data_last  = last_q;
  assign o_overflow   = ovf_q;
endmodule

// File: tb/tb_frame_accumulator.sv
// Scoreboard bench: three configurations (sum/saturate, average of 4, tiny frame buffer).
module tb_frame_accumulator;
  localparam int ND = 3;

  typedef struct packed {
    logic [1:0]  dut;
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fl [ND];
  logic        dv [ND];
  logic        ir [ND];
  logic        rdy[ND];
  logic        ov [ND];
  logic        ol [ND];
  logic        ovf[ND];
  logic [31:0] din [ND];
  logic [31:0] dout[ND];

  logic [31:0] fr[4][256];
  exp_t        exp_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  bit          bp = 1'b0;
  int          cyc = 0;

  logic [31:0] pd[ND] = '{default: 32'h0};
  logic        pv[ND] = '{default: 1'b0};
  logic        pr[ND] = '{default: 1'b0};
  logic        pl[ND] = '{default: 1'b0};
  logic        px[ND] = '{default: 1'b1};

  always #5 clk = ~clk;

  frame_accumulator #(.DATA_W(32), .FRAME_LEN(256), .NUM_FRAMES(2), .AVG_MODE(0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_flush(fl[0]), .i_data(din[0]), .i_data_valid(dv[0]),
    .o_data_ready(rdy[0]), .o_data(dout[0]), .o_data_valid(ov[0]), .o_data_last(ol[0]),
    .i_data_ready(ir[0]), .o_overflow(ovf[0]));

  frame_accumulator #(.DATA_W(32), .FRAME_LEN(256), .NUM_FRAMES(4), .AVG_MODE(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_flush(fl[1]), .i_data(din[1]), .i_data_valid(dv[1]),
    .o_data_ready(rdy[1]), .o_data(dout[1]), .o_data_valid(ov[1]), .o_data_last(ol[1]),
    .i_data_ready(ir[1]), .o_overflow(ovf[1]));

  frame_accumulator #(.DATA_W(32), .FRAME_LEN(4), .NUM_FRAMES(1), .AVG_MODE(1)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_flush(fl[2]), .i_data(din[2]), .i_data_valid(dv[2]),
    .o_data_ready(rdy[2]), .o_data(dout[2]), .o_data_valid(ov[2]), .o_data_last(ol[2]),
    .i_data_ready(ir[2]), .o_overflow(ovf[2]));

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic int flen(input int s);
    return (s == 2) ? 4 : 256;
  endfunction

  function automatic int nfr(input int s);
    return (s == 0) ? 2 : (s == 1) ? 4 : 1;
  endfunction

  // Output value from the true bin sum: saturate for dut0, floor average otherwise.
  function automatic logic [31:0] ref_out(input int s, input longint sum);
    longint q;
    if (s == 0) begin
      if (sum > 64'sd2147483647)  return 32'h7FFF_FFFF;
      if (sum < -64'sd2147483648) return 32'h8000_0000;
      return 32'(sum);
    end
    q = sum / nfr(s);
    if (q * nfr(s) > sum) q = q - 1;
    return 32'(q);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int s, input logic [31:0] v, input bit gaps);
    int  g;
    bit  done;
    g    = 0;
    done = 1'b0;
    while (!done) begin
      din[s] = v;
      dv[s]  = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      done   = dv[s] && rdy[s];
      step();
      g++;
      if (!done && g > 5000) begin
        n_chk++;
        n_fail++;
        $display("FAIL send_timeout: dut %0d never ready, expected ready within 5000 cycles", s);
        done = 1'b1;
      end
    end
    dv[s] = 1'b0;
  endtask

  task automatic issue(input int s, input bit gaps, input int nsend, input bit push);
    exp_t   e;
    longint sum;
    for (int k = 0; k < flen(s); k++) begin
      sum = 0;
      for (int f = 0; f < nfr(s); f++) sum += longint'($signed(fr[f][k]));
      e.dut  = 2'(s);
      e.data = ref_out(s, sum);
      e.last = (k == flen(s) - 1);
      if (push) exp_q.push_back(e);
    end
    for (int n = 0; n < nsend; n++) send(s, fr[n / flen(s)][n % flen(s)], gaps);
  endtask

  task automatic wait_drain(input string nm);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 5000) begin
      step();
      g++;
    end
    chk(nm, exp_q.size(), 0);
    step();
  endtask

  task automatic fill_rand();
    for (int f = 0; f < 4; f++)
      for (int k = 0; k < 256; k++) fr[f][k] = $urandom();
  endtask

  task automatic fill_const(input logic [31:0] c);
    for (int f = 0; f < 4; f++)
      for (int k = 0; k < 256; k++) fr[f][k] = c;
  endtask

  // Downstream ready: always 1, or the 1,0,0,1 backpressure pattern.
  initial begin
    for (int i = 0; i < ND; i++) ir[i] = 1'b1;
    forever begin
      step();
      cyc++;
      for (int i = 0; i < ND; i++) ir[i] = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < ND; i++) begin
      if (pv[i] && !pr[i] && !px[i]) begin
        chk("hold_valid", ov[i], 1);
        chk("hold_data", dout[i], pd[i]);
        chk("hold_last", ol[i], pl[i]);
      end
      if (ov[i] && ir[i] && !fl[i] && !rst) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_output: dut %0d presented %0h, expected no output", i, dout[i]);
        end else begin
          chk("out_dut", i, exp_q[0].dut);
          chk("out_data", dout[i], exp_q[0].data);
          chk("out_last", ol[i], exp_q[0].last);
          void'(exp_q.pop_front());
        end
      end
      pv[i] <= ov[i];
      pr[i] <= ir[i];
      pd[i] <= dout[i];
      pl[i] <= ol[i];
      px[i] <= fl[i] | rst;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    for (int i = 0; i < ND; i++) begin
      fl[i]  = 1'b0;
      dv[i]  = 1'b0;
      din[i] = '0;
    end
    rst = 1'b1;
    repeat (3) step();
    for (int i = 0; i < ND; i++) begin
      chk("rst_ready", rdy[i], 0);
      chk("rst_valid", ov[i], 0);
      chk("rst_last", ol[i], 0);
      chk("rst_data", dout[i], 0);
      chk("rst_ovf", ovf[i], 0);
    end
    rst = 1'b0;
    step();
    for (int i = 0; i < ND; i++) chk("ready_after_rst", rdy[i], 1);

    // Sum: k + 2k = 3k, full throughput.
    for (int k = 0; k < 256; k++) begin
      fr[0][k] = 32'(k);
      fr[1][k] = 32'(2 * k);
    end
    issue(0, 1'b0, 512, 1'b1);
    chk("sum_latency_valid", ov[0], 1);
    cnt = 0;
    while (!rdy[0] && cnt < 1000) begin
      cnt++;
      step();
    end
    chk("sum_ready_low_cycles", cnt, 256);
    wait_drain("sum_drained");
    chk("sum_no_ovf", ovf[0], 0);

    // Saturation and flush clearing the sticky flag.
    fill_const(32'h7FFF_FFF0);
    issue(0, 1'b0, 512, 1'b1);
    wait_drain("sat_drained");
    chk("sat_ovf_set", ovf[0], 1);
    fl[0] = 1'b1;
    step();
    fl[0] = 1'b0;
    chk("flush_clears_ovf", ovf[0], 0);
    chk("flush_ready", rdy[0], 1);

    // Backpressure with random input gaps, two back-to-back output frames.
    bp = 1'b1;
    for (int r = 0; r < 2; r++) begin
      fill_rand();
      issue(0, 1'b1, 512, 1'b1);
      wait_drain("bp_drained");
    end
    bp = 1'b0;
    step();

    // Reset at sample 100 of frame 1, then clean frames of ones.
    fill_rand();
    issue(0, 1'b0, 356, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_ready", rdy[0], 0);
    chk("midrst_valid", ov[0], 0);
    chk("midrst_last", ol[0], 0);
    chk("midrst_data", dout[0], 0);
    chk("midrst_ovf", ovf[0], 0);
    step();
    step();
    rst = 1'b0;
    step();
    chk("midrst_ready_back", rdy[0], 1);
    fill_const(32'd1);
    issue(0, 1'b0, 512, 1'b1);
    wait_drain("post_rst_drained");

    // Flush while presenting bin 50 of a drain.
    fill_rand();
    issue(0, 1'b0, 512, 1'b1);
    repeat (50) step();
    fl[0] = 1'b1;
    step();
    fl[0] = 1'b0;
    chk("flush_valid_drop", ov[0], 0);
    chk("flush_left", exp_q.size(), 206);
    exp_q.delete();
    chk("flush_ready_drain", rdy[0], 1);
    fill_const(32'd1);
    issue(0, 1'b0, 512, 1'b1);
    wait_drain("post_flush_drained");

    // Average of four frames: (-8-8-8-4)/4 = -7.
    fill_const(32'hFFFF_FFF8);
    for (int k = 0; k < 256; k++) fr[3][k] = 32'hFFFF_FFFC;
    issue(1, 1'b0, 1024, 1'b1);
    chk("avg_latency_valid", ov[1], 1);
    wait_drain("avg_drained");
    chk("avg_no_ovf", ovf[1], 0);
    bp = 1'b1;
    fill_rand();
    issue(1, 1'b1, 1024, 1'b1);
    wait_drain("avg_rand_drained");
    bp = 1'b0;
    step();

    // Four-sample frame buffer.
    fr[0][0] = 32'd5;
    fr[0][1] = 32'd6;
    fr[0][2] = 32'd7;
    fr[0][3] = 32'd8;
    issue(2, 1'b0, 4, 1'b1);
    chk("corner_latency_valid", ov[2], 1);
    chk("corner_ready_low", rdy[2], 0);
    wait_drain("corner_drained");
    bp = 1'b1;
    fill_rand();
    issue(2, 1'b1, 4, 1'b1);
    wait_drain("corner_rand_drained");
    bp = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/frame_accumulator.md
Name: frame_accumulator

Overview:
- Parametrised successor to the two-window FFT output combiner. Sums NUM_FRAMES consecutive FFT output frames of FRAME_LEN samples, bin by bin, in an internal buffer, then streams out the summed frame or the averaged frame.
- Sits between the FFT core output and the host/DMA stream.
- Adds:
  - configurable frame count and width;
  - signed widened accumulation;
  - average or saturate output mode;
  - tlast marker;
  - sticky overflow flag;
  - synchronous flush.

Parameters:
- DATA_W, 32: signed sample width, input and output.
- FRAME_LEN, 256: samples per frame. Power of 2, 4 to 4096.
- NUM_FRAMES, 2: frames accumulated per output frame. Power of 2, 1 to 256.
- AVG_MODE, 1: 1 = output is sum >>> log2(NUM_FRAMES) (arithmetic shift). 0 = output is sum saturated to DATA_W.
- ACC_W, DATA_W+log2(NUM_FRAMES): accumulator width. Derived, not overridable.

Ports:
- i_clk, in, 1: clock.
- i_rst, in, 1: asynchronous, active-high reset.
- i_flush, in, 1: synchronous abort. Returns the block to ACCUM, frame 0, sample 0.
- i_data, in, DATA_W: signed input sample.
- i_data_valid, in, 1: input valid.
- o_data_ready, out, 1: input ready.
- o_data, out, DATA_W: output sample.
- o_data_valid, out, 1: output valid.
- o_data_last, out, 1: high with the last sample of an output frame.
- i_data_ready, in, 1: downstream ready.
- o_overflow, out, 1: sticky flag; set on any saturation in AVG_MODE=0. Cleared by reset or i_flush.

Behaviour:
- Handshakes:
  - input accepted when i_data_valid & o_data_ready;
  - output taken when o_data_valid & i_data_ready.
- Reset values: o_data_ready=0 while i_rst is high, o_data=0, o_data_valid=0, o_data_last=0, o_overflow=0. Counters and state are 0/ACCUM.
  - o_data_ready goes to 1 on the first clock after i_rst deasserts.
  - Buffer contents are not reset; frame 0 overwrites them.
- Storage: FRAME_LEN x ACC_W array, combinational read, synchronous write. Counters:
  - samp_idx: log2(FRAME_LEN) bits;
  - frm_idx: log2(NUM_FRAMES) bits, at least 1;
  - rd_idx: log2(FRAME_LEN) bits.
- State ACCUM:
  - o_data_ready=1, o_data_valid=0.
  - Per accepted sample: mem[samp_idx] <= (frm_idx==0) ? sext(i_data) : mem[samp_idx] + sext(i_data). Then samp_idx++.
  - Read-modify-write completes in the same cycle, so back-to-back accepts need no stall.
  - samp_idx wraps FRAME_LEN-1 -> 0 and frm_idx increments.
  - Accepting sample FRAME_LEN-1 of frame NUM_FRAMES-1 moves the block to DRAIN on the next edge.
  - That write must land in mem before the first read in DRAIN; bypass the written value if the read address collides.
- State DRAIN:
  - o_data_ready=0.
  - The output register loads conv(mem[rd_idx]).
  - o_data_valid=1 on the first cycle in DRAIN. Latency: the last input accept edge is followed by valid on the next cycle.
  - o_data, o_data_valid and o_data_last are held stable while i_data_ready=0.
  - On each taken sample, rd_idx++ and the register reloads the next sample the same edge. Full throughput at 1 sample/cycle.
  - o_data_last=1 when rd_idx==FRAME_LEN-1.
  - Taking the last sample: o_data_valid=0, rd_idx=0, frm_idx=0, samp_idx=0, state returns to ACCUM. o_data_ready=1 on the following cycle.
- conv():
  - AVG_MODE=1: acc >>> log2(NUM_FRAMES), truncated to DATA_W. This is exact; no overflow is possible.
  - AVG_MODE=0: if acc > 2^(DATA_W-1)-1, output max; if acc < -2^(DATA_W-1), output min; set o_overflow on either.
- NUM_FRAMES=1: the block behaves as a frame buffer (store then forward, no arithmetic).
- i_flush:
  - Has priority over every handshake in the same cycle.
  - The input sample presented that cycle is discarded.
  - Any drain in progress is abandoned: o_data_valid=0 next cycle.
- Reset mid-frame or mid-drain: all state returns to reset values; the partial frame is lost.

Decomposition:
- Shared package fft_stream_pkg:
  - clog2 function;
  - state encoding constants ST_ACCUM / ST_DRAIN;
  - default DATA_W and FRAME_LEN constants shared with the FFT core.
- One sub-module: acc_ram (FRAME_LEN x ACC_W, combinational read port, one write port with write-to-read bypass). Its contents can later map to block RAM with a 1-cycle read pipeline.

Test Plan:
- Sum, full throughput, 8-bit style values. DATA_W=32, FRAME_LEN=256, NUM_FRAMES=2, AVG_MODE=0; frame A sample k = k, frame B sample k = 2k, i_data_ready=1 -> output k = 3k. o_data_last only on k=255. o_data_ready low for exactly 256 cycles. o_overflow=0.
- Average mode. NUM_FRAMES=4, AVG_MODE=1, frames of constant -8, -8, -8, -4 -> every output = -7 (-28>>>2); o_data_last on sample 255.
- Saturation. AVG_MODE=0, NUM_FRAMES=2, both frames 0x7FFFFFF0 -> every output 0x7FFFFFFF and o_overflow=1. After i_flush: o_overflow=0.
- Backpressure. i_data_ready toggles 1,0,0,1 and input valid is random -> no sample dropped or duplicated; o_data stays stable while not taken; second output frame uses freshly overwritten frame-0 data.
- Reset/flush mid-operation. Assert i_rst at input sample 100 of frame 1 -> all outputs 0. Then two clean frames of 1 each -> outputs all 2, with no stale data. Same check using i_flush during DRAIN at rd_idx=50.
- Corner case. FRAME_LEN=4, NUM_FRAMES=1 -> input 5,6,7,8 is output as 5,6,7,8 with last on 8. Valid is seen the cycle after the 4th accept.
